// File: rtl/upe_serial_out32.sv
// upe_serial_out32: bit-serial output stage that shifts one accepted word out on a single pin
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   in_data    word to serialise
//   in_valid   in_data is valid
//   in_ready   block can accept a word (registered)
//   bit_out    current serial bit
//   bit_strobe one-cycle pulse on the first cycle of every data bit
//   frame      high while data bits are on bit_out, low during the gap
//   done       one-cycle pulse once a word and its gap have completed
module upe_serial_out32 #(
    parameter int WIDTH     = 32,
    parameter int TICKS     = 1250,
    parameter int GAP_BITS  = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_strobe,
    output logic             frame,
    output logic             done
);
    localparam int TW = $clog2(TICKS + 1);
    localparam int BW = $clog2(WIDTH + GAP_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TICKS - 1);
    localparam logic [BW-1:0] W_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] G_LAST = BW'(GAP_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             bit_next;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    bcnt;

    // bit_next is the bit that becomes current after the next shift
    assign sr_next  = MSB_FIRST ? sr << 1 : sr >> 1;
    assign bit_next = MSB_FIRST ? sr[WIDTH-2] : sr[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            tick       <= '0;
            bcnt       <= '0;
            in_ready   <= 1'b0;
            bit_out    <= 1'b0;
            bit_strobe <= 1'b0;
            frame      <= 1'b0;
            done       <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state      <= SHIFT;
                        sr         <= in_data;
                        tick       <= '0;
                        bcnt       <= '0;
                        in_ready   <= 1'b0;
                        bit_out    <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
                        bit_strobe <= 1'b1;
                        frame      <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick != T_LAST) begin
                        tick <= tick + 1'b1;
                    end else begin
                        tick <= '0;
                        if (bcnt == W_LAST) begin
                            // bcnt is reused to count gap bit periods
                            bcnt    <= '0;
                            frame   <= 1'b0;
                            bit_out <= 1'b0;
                            if (GAP_BITS > 0) begin
                                state <= GAP;
                            end else begin
                                state    <= IDLE;
                                done     <= 1'b1;
                                in_ready <= 1'b1;
                            end
                        end else begin
                            bcnt       <= bcnt + 1'b1;
                            sr         <= sr_next;
                            bit_out    <= bit_next;
                            bit_strobe <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick != T_LAST) begin
                        tick <= tick + 1'b1;
                    end else begin
                        tick <= '0;
                        if (bcnt == G_LAST) begin
                            state    <= IDLE;
                            bcnt     <= '0;
                            done     <= 1'b1;
                            in_ready <= 1'b1;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/upe_serial_out32.md
# upe_serial_out32

Bit-serial output stage that sits directly downstream of the 32-bit negate unit. It accepts one 32-bit result word through a valid/ready handshake and shifts it out one bit at a time on a single output pin. Each bit is held for a programmable number of clock cycles, so a word can be read off an LED or a logic probe on the iCE40 low-frequency oscillator. After each word it drives a fixed low inter-word gap and pulses a completion strobe.

## Interface
- WIDTH, 32: word width in bits; must be ≥2.
- TICKS, 1250: clock cycles each bit is held on `bit_out`; must be ≥1.
- GAP_BITS, 4: bit periods of forced-low gap after the last data bit; 0 means no gap.
- MSB_FIRST, 0: 0 shifts bit 0 first; 1 shifts bit WIDTH-1 first.
- clk  input  1  single clock (10 kHz SB_LFOSC in the target build).
- rst_n  input  1  asynchronous, active-low reset; one clock, no other clock domains.
- in_data  input  WIDTH  word to serialise, normally the negate unit's `Out`.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- bit_out  output  1  current serial bit.
- bit_strobe  output  1  one-cycle pulse on the first cycle of every data bit.
- frame  output  1  high while data bits are on bit_out; excludes the gap.
- done  output  1  one-cycle pulse when a word, including its gap, has completed.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: data bits on bit_out, frame=1.
  - GAP: bit_out=0, frame=0.
- Registers:
  - shift register, WIDTH bits.
  - tick counter, width $clog2(TICKS+1).
  - bit counter, width $clog2(WIDTH+GAP_BITS+1).
- IDLE→SHIFT on a clock edge with in_valid & in_ready:
  - load in_data into the shift register.
  - clear both counters.
  - assert bit_strobe and frame on the next cycle.
- SHIFT:
  - tick counter counts 0..TICKS-1.
  - at terminal count: shift by one bit (LSB-first right shift, MSB-first left shift), increment bit counter, pulse bit_strobe.
  - after the WIDTH-th bit period: go to GAP if GAP_BITS>0, otherwise straight to IDLE with done=1.
- GAP:
  - bit_out=0 for GAP_BITS*TICKS cycles.
  - then go to IDLE with a done pulse.
- in_valid and in_data are ignored outside IDLE. The captured word is immune to input changes after acceptance.
- Back-to-back: if in_valid is high in the IDLE cycle where done pulses, the next word is accepted on that edge. No extra idle cycles are inserted.
- Asynchronous reset, including mid-word:
  - state=IDLE, counters=0, shift register=0.
  - bit_out=0, bit_strobe=0, frame=0, done=0, in_ready=0.
  - the partial word is discarded.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.

## Timing
- All outputs are registered. No combinational path from in_* to any output.
- Acceptance edge E (clock edge numbering):
  - bit k is on bit_out for cycles E+1+k*TICKS through E+(k+1)*TICKS.
  - bit_strobe is high at cycle E+1+k*TICKS, for k=0..WIDTH-1.
- frame is high for exactly WIDTH*TICKS cycles, starting at cycle E+1.
- GAP spans cycles E+1+WIDTH*TICKS through E+(WIDTH+GAP_BITS)*TICKS.
- done and in_ready=1 occur at cycle E+1+(WIDTH+GAP_BITS)*TICKS.
- Word period at continuous valid: (WIDTH+GAP_BITS)*TICKS+1 cycles.
- TICKS=1: one bit per clock. bit_strobe is high continuously during SHIFT.

## Test plan
- Reset and first word (TICKS=4, GAP_BITS=2, LSB-first):
  - after reset release, in_ready=1 on the first edge.
  - send 32'h34D51531.
  - bit_out first 8 bits = 1,0,0,0,1,1,0,0, each held 4 cycles.
  - bit_strobe count = 32; frame width = 128 cycles.
  - gap = 8 cycles low; done at E+137.
- MSB-first (TICKS=4, MSB_FIRST=1):
  - send 32'hCB2AEACF.
  - first 8 bits = 1,1,0,0,1,0,1,1.
  - reconstructed word matches the input.
- Back-to-back (TICKS=2, GAP_BITS=0):
  - in_valid held high with words 32'h00000001 then 32'hFFFFFFFF.
  - second acceptance at the done edge.
  - word period = 65 cycles; second frame all ones.
- Input stability: change in_data and pulse in_valid during SHIFT → output bits unchanged, in_ready stays 0, no second acceptance.
- Reset mid-word: assert rst_n low at bit 10 → bit_out, frame and done go 0 immediately, in_ready=0. After release, a new word 32'hA5A5A5A5 serialises correctly from bit 0.
- TICKS=1, GAP_BITS=0 edge case: word 32'h80000000 LSB-first → 31 cycles low then 1 cycle high; done on the next cycle.
